// File: rtl/mem_arbiter_rr.sv
// rtl/mem_arbiter_rr.sv - round-robin SDRAM command arbiter with atomic write bursts
//
// Ports:
//   clkSYS, reset      system clock, synchronous active-high reset
//   req/wr/addr/data   per-requester command inputs (requester i at slice i)
//   ack                one-cycle accept strobe back to the granted requester
//   valid              read-data strobe routed by mem_rid
//   mem_req/mem_wr/mem_addr/mem_data/mem_id   command port to the SDRAM controller
//   mem_ack            controller accepted the current command / write word
//   mem_valid/mem_rid  read word return and the ID it belongs to

module mem_arbiter_rr #(
    parameter int AN    = 24,
    parameter int DN    = 16,
    parameter int N     = 4,
    parameter int IDN   = 2,
    parameter int BURST = 8
) (
    input  logic              clkSYS,
    input  logic              reset,
    input  logic [N-1:0]      req,
    input  logic [N-1:0]      wr,
    input  logic [N*AN-1:0]   addr,
    input  logic [N*DN-1:0]   data,
    output logic [N-1:0]      ack,
    output logic [N-1:0]      valid,
    output logic              mem_req,
    output logic              mem_wr,
    output logic [AN-1:0]     mem_addr,
    output logic [DN-1:0]     mem_data,
    output logic [IDN-1:0]    mem_id,
    input  logic              mem_ack,
    input  logic              mem_valid,
    input  logic [IDN-1:0]    mem_rid
);

    localparam int CW  = $clog2(BURST) + 1;
    localparam int NID = 1 << IDN;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_GRANT  = 2'd1;
    localparam logic [1:0] ST_WBURST = 2'd2;

    localparam logic [IDN-1:0] LAST_RST = IDN'(N - 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(BURST - 1);

    logic [1:0]     state_q, state_d;
    logic [IDN-1:0] gnt_q,   gnt_d;
    logic [IDN-1:0] last_q,  last_d;
    logic [CW-1:0]  cnt_q,   cnt_d;

    // req/wr padded to the full ID space so they can be indexed directly by gnt
    logic [NID-1:0] req_ext;
    logic [NID-1:0] wr_ext;
    logic           req_g;
    logic           wr_g;
    logic           accept;
    logic [IDN-1:0] next_gnt;
    logic           any_req;

    always_comb begin
        req_ext        = '0;
        wr_ext         = '0;
        req_ext[N-1:0] = req;
        wr_ext[N-1:0]  = wr;
    end

    assign req_g   = req_ext[gnt_q];
    assign wr_g    = wr_ext[gnt_q];
    assign any_req = |req;

    // Rotating search starting at last+1. Scanning from the farthest offset
    // down to the nearest lets the closest requesting index win.
    always_comb begin
        int idx;
        next_gnt = last_q;
        for (int k = N; k >= 1; k--) begin
            idx = (int'(last_q) + k) % N;
            if (req_ext[IDN'(idx)]) begin
                next_gnt = IDN'(idx);
            end
        end
    end

    // Command path is a pure mux on the grant register.
    always_comb begin
        mem_addr = addr[AN-1:0];
        mem_data = data[DN-1:0];
        for (int i = 0; i < N; i++) begin
            if (gnt_q == IDN'(i)) begin
                mem_addr = addr[i*AN +: AN];
                mem_data = data[i*DN +: DN];
            end
        end
    end

    assign mem_req = (state_q != ST_IDLE) && req_g;
    assign mem_wr  = (state_q == ST_WBURST) || ((state_q == ST_GRANT) && wr_g);
    assign mem_id  = gnt_q;
    assign accept  = mem_ack && mem_req;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            ack[i]   = accept && (gnt_q == IDN'(i));
            valid[i] = mem_valid && (mem_rid == IDN'(i));
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    gnt_d   = next_gnt;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (!req_g) begin
                    // withdrawn before acceptance; not counted as served
                    state_d = ST_IDLE;
                end else if (accept) begin
                    if (!wr_g || (BURST == 1)) begin
                        last_d  = gnt_q;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d   = CW'(1);
                        state_d = ST_WBURST;
                    end
                end
            end
            ST_WBURST: begin
                // grant stays locked even while req is low so the burst stays atomic
                if (accept) begin
                    if (cnt_q == CNT_LAST) begin
                        last_d  = gnt_q;
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clkSYS) begin
        if (reset) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            last_q  <= LAST_RST;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// tb/tb_mem_arbiter_rr.sv - self-checking bench for mem_arbiter_rr

module tb_mem_arbiter_rr;

    localparam int AN    = 24;
    localparam int DN    = 16;
    localparam int N     = 4;
    localparam int IDN   = 2;
    localparam int BURST = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0]      req;
    logic [N-1:0]      wr;
    logic [N*AN-1:0]   addr;
    logic [N*DN-1:0]   data;
    logic [N-1:0]      ack;
    logic [N-1:0]      valid;
    logic              mem_req;
    logic              mem_wr;
    logic [AN-1:0]     mem_addr;
    logic [DN-1:0]     mem_data;
    logic [IDN-1:0]    mem_id;
    logic              mem_ack;
    logic              mem_valid;
    logic [IDN-1:0]    mem_rid;

    always #5 clk = ~clk;

    mem_arbiter_rr #(.AN(AN), .DN(DN), .N(N), .IDN(IDN), .BURST(BURST)) dut (
        .clkSYS    (clk),
        .reset     (reset),
        .req       (req),
        .wr        (wr),
        .addr      (addr),
        .data      (data),
        .ack       (ack),
        .valid     (valid),
        .mem_req   (mem_req),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .mem_id    (mem_id),
        .mem_ack   (mem_ack),
        .mem_valid (mem_valid),
        .mem_rid   (mem_rid)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(string tag, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: who owns the port, whether the owner is mid-burst,
    // and how many words of that burst have been accepted.
    bit             m_busy;
    bit             m_locked;
    int             m_words;
    logic [IDN-1:0] m_own;
    logic [IDN-1:0] m_gnt;
    logic [IDN-1:0] m_last;
    logic [N-1:0]   prev_ack;

    task automatic model_reset();
        m_busy   = 1'b0;
        m_locked = 1'b0;
        m_words  = 0;
        m_own    = '0;
        m_gnt    = '0;
        m_last   = IDN'(N - 1);
    endtask

    // Compare every output against the model for the inputs now applied.
    task automatic settle_check();
        logic [N-1:0] e_ack;
        logic [N-1:0] e_valid;
        logic         e_req;
        logic         e_wr;
        #2;
        e_req   = m_busy && req[m_own];
        e_wr    = m_busy && (m_locked || wr[m_own]);
        e_ack   = '0;
        if (e_req && mem_ack) e_ack[m_own] = 1'b1;
        e_valid = '0;
        if (mem_valid && (int'(mem_rid) < N)) e_valid[mem_rid] = 1'b1;
        check_eq("mem_req",  64'(mem_req),  64'(e_req));
        check_eq("mem_wr",   64'(mem_wr),   64'(e_wr));
        check_eq("mem_id",   64'(mem_id),   64'(m_gnt));
        check_eq("mem_addr", 64'(mem_addr), 64'(addr[int'(m_gnt)*AN +: AN]));
        check_eq("mem_data", 64'(mem_data), 64'(data[int'(m_gnt)*DN +: DN]));
        check_eq("ack",      64'(ack),      64'(e_ack));
        check_eq("valid",    64'(valid),    64'(e_valid));
        prev_ack = e_ack;
    endtask

    task automatic tick();
        logic [N-1:0] r;
        logic [N-1:0] w;
        logic         acc;
        bit           found;
        int           idx;
        @(posedge clk);
        r     = req;
        w     = wr;
        acc   = mem_ack;
        found = 1'b0;
        if (reset) begin
            model_reset();
        end else if (!m_busy) begin
            for (int k = 1; k <= N; k++) begin
                idx = (int'(m_last) + k) % N;
                if (!found && r[IDN'(idx)]) begin
                    found  = 1'b1;
                    m_own  = IDN'(idx);
                    m_gnt  = IDN'(idx);
                    m_busy = 1'b1;
                end
            end
        end else if (!m_locked) begin
            if (!r[m_own]) begin
                m_busy = 1'b0;
            end else if (acc) begin
                if (!w[m_own] || BURST == 1) begin
                    m_last = m_own;
                    m_busy = 1'b0;
                end else begin
                    m_locked = 1'b1;
                    m_words  = 1;
                end
            end
        end else if (r[m_own] && acc) begin
            m_words++;
            if (m_words == BURST) begin
                m_last   = m_own;
                m_busy   = 1'b0;
                m_locked = 1'b0;
                m_words  = 0;
            end
        end
        #1;
    endtask

    task automatic cycle();
        settle_check();
        tick();
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        req       = '0;
        wr        = '0;
        mem_ack   = 1'b0;
        mem_valid = 1'b0;
        mem_rid   = '0;
        cycle();
        cycle();
        reset = 1'b0;
    endtask

    initial begin
        addr = '0;
        data = '0;
        prev_ack = '0;
        model_reset();
        do_reset();

        // reset state
        settle_check();
        check_eq("rst_mem_req", 64'(mem_req), 64'(0));
        check_eq("rst_ack",     64'(ack),     64'(0));
        check_eq("rst_mem_wr",  64'(mem_wr),  64'(0));
        check_eq("rst_mem_id",  64'(mem_id),  64'(0));
        tick();

        // single read from requester 0, accepted on the 2nd mem_req cycle
        req = 4'b0001;
        addr[0 +: AN] = 24'h000100;
        settle_check();
        check_eq("t1_arb_req", 64'(mem_req), 64'(0));
        tick();
        settle_check();
        check_eq("t1_req",  64'(mem_req),  64'(1));
        check_eq("t1_addr", 64'(mem_addr), 64'h000100);
        check_eq("t1_id",   64'(mem_id),   64'(0));
        check_eq("t1_noack", 64'(ack),     64'(0));
        tick();
        mem_ack = 1'b1;
        settle_check();
        check_eq("t1_ack", 64'(ack), 64'(4'b0001));
        tick();
        req = '0;
        mem_ack = 1'b0;
        settle_check();
        check_eq("t1_idle", 64'(mem_req), 64'(0));
        tick();

        // all four read continuously: grants 0,1,2,3,0,1 with one idle cycle between
        do_reset();
        req = 4'b1111;
        wr = '0;
        mem_ack = 1'b1;
        for (int c = 0; c < 12; c++) begin
            settle_check();
            check_eq($sformatf("rot_c%0d", c), 64'(ack),
                     (c % 2 == 1) ? 64'(1 << ((c / 2) % N)) : 64'(0));
            tick();
        end

        // write burst from 2 while 1 waits to read; valid routed to 3 meanwhile
        do_reset();
        req = 4'b0100;
        wr = 4'b0100;
        mem_ack = 1'b1;
        cycle();
        req = 4'b0110;
        for (int c = 1; c <= 10; c++) begin
            mem_valid = (c <= 8);
            mem_rid   = 2'd3;
            settle_check();
            if (c <= 8) begin
                check_eq($sformatf("wb_ack%0d", c), 64'(ack),    64'(4'b0100));
                check_eq($sformatf("wb_wr%0d", c),  64'(mem_wr), 64'(1));
                check_eq($sformatf("wb_id%0d", c),  64'(mem_id), 64'(2));
                check_eq($sformatf("wb_vld%0d", c), 64'(valid),  64'(4'b1000));
            end else begin
                check_eq($sformatf("wb_after%0d", c), 64'(ack),
                         (c == 10) ? 64'(4'b0010) : 64'(0));
            end
            tick();
        end
        mem_valid = 1'b0;

        // requester 2 drops req after word 3 for 5 cycles; burst stays locked
        do_reset();
        req = 4'b0100;
        wr = 4'b0100;
        mem_ack = 1'b1;
        cycle();
        for (int c = 1; c <= 3; c++) cycle();
        req = 4'b0001;
        wr = 4'b0101;
        for (int c = 0; c < 5; c++) begin
            settle_check();
            check_eq($sformatf("drop_req%0d", c), 64'(mem_req), 64'(0));
            check_eq($sformatf("drop_ack%0d", c), 64'(ack),     64'(0));
            tick();
        end
        req = 4'b0101;
        for (int c = 4; c <= 8; c++) begin
            settle_check();
            check_eq($sformatf("resume_ack%0d", c), 64'(ack), 64'(4'b0100));
            tick();
        end
        cycle();
        settle_check();
        check_eq("after_drop_ack", 64'(ack), 64'(4'b0001));
        tick();

        // reset at word 5 of a burst
        do_reset();
        req = 4'b0101;
        wr = 4'b0101;
        mem_ack = 1'b1;
        for (int c = 0; c <= 4; c++) cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        settle_check();
        check_eq("rstmid_req", 64'(mem_req), 64'(0));
        check_eq("rstmid_ack", 64'(ack),     64'(0));
        tick();
        settle_check();
        check_eq("rstmid_first", 64'(ack), 64'(4'b0001));
        tick();

        // randomized traffic against the model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                data[i*DN +: DN] = DN'($urandom);
                if (req[i]) begin
                    if ((prev_ack[i] && ($urandom % 2 == 0)) || ($urandom % 100 < 3))
                        req[i] = 1'b0;
                end else if ($urandom % 4 == 0) begin
                    req[i] = 1'b1;
                    wr[i]  = 1'($urandom);
                    addr[i*AN +: AN] = AN'($urandom);
                end
            end
            mem_ack   = ($urandom % 10) < 6;
            mem_valid = 1'($urandom);
            mem_rid   = IDN'($urandom);
            reset     = ($urandom % 300) == 0;
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_arbiter_rr.md
Name: mem_arbiter_rr

Overview:
- Round-robin arbiter sharing the single SDRAM command port between N requesters (TFT fetch, display writer, future DMA) in the clkSYS domain.
- Alternative to the fixed-priority arbiter. Guarantees no starvation and keeps each write burst atomic.
- Routes read-data valid strobes back to the issuing requester by ID.

Parameters:
- AN, 24, address width in words
- DN, 16, data width
- N, 4, number of requesters (2..8)
- IDN, 2, requester ID width; must satisfy 2^IDN >= N
- BURST, 8, words per write burst; words returned per read command

Ports:
- clkSYS  input  1  system clock
- reset  input  1  synchronous active-high reset
- req  input  N  per-requester command request, held until ack
- wr  input  N  per-requester write flag, qualified by req
- addr  input  N*AN  per-requester address, requester i at [i*AN +: AN]
- data  input  N*DN  per-requester write data, requester i at [i*DN +: DN]
- ack  output  N  one-cycle accept strobe to requester i
- valid  output  N  read-data strobe for requester i
- mem_req  output  1  command request to SDRAM controller
- mem_wr  output  1  command is a write
- mem_addr  output  AN  command address
- mem_data  output  DN  write data
- mem_id  output  IDN  requester ID tagged on the command
- mem_ack  input  1  SDRAM controller accepted current command/word
- mem_valid  input  1  read word valid from SDRAM controller
- mem_rid  input  IDN  ID of the returned read word

Behaviour:
- Single clock, synchronous active-high reset. All state registers update on posedge clkSYS.
- State registers: state {IDLE, GRANT, WBURST}; gnt (IDN bits); last (IDN bits); cnt (ceil(log2 BURST)+1 bits).
- Reset values: state=IDLE, gnt=0, last=N-1, cnt=0. Requester 0 therefore wins the first arbitration.
- Outputs after reset: mem_req=0, ack=0, valid=0, mem_wr=0, mem_id=0.
- Command outputs are combinational from gnt. This adds no latency beyond the grant register.
  - mem_addr, mem_data and mem_wr follow requester gnt.
  - mem_id = gnt.
  - mem_req = (state!=IDLE) & req[gnt].
  - In states other than IDLE, mem_wr is forced to 1 in WBURST.
- ack[i] = mem_ack & mem_req & (gnt==i). All other ack bits are 0.
- IDLE:
  - If any req is set, select the first requester with req=1, searching upward from last+1 modulo N.
  - Load gnt with that requester and go to GRANT. The decision takes one cycle.
  - If no req is set, remain in IDLE.
- GRANT:
  - If req[gnt]=0 (requester withdrew before ack): go to IDLE, last unchanged.
  - On mem_ack with wr[gnt]=0 (read command): last<=gnt, go to IDLE. One read command covers BURST words.
  - On mem_ack with wr[gnt]=1:
    - If BURST==1: last<=gnt, go to IDLE.
    - Otherwise: cnt<=1, go to WBURST.
- WBURST:
  - Grant is locked. Other requesters are never selected until the burst completes.
  - Each mem_ack increments cnt.
  - On mem_ack with cnt==BURST-1: last<=gnt, cnt<=0, go to IDLE.
  - If req[gnt] drops mid-burst, mem_req deasserts but the state stays locked. The burst resumes when req returns.
- Fairness: a requester that has just been served moves to lowest priority. With all N requesting continuously, grants rotate 0,1,..,N-1,0.
- Minimum gap between consecutive commands is one idle cycle (the IDLE arbitration cycle).
- Read return path:
  - valid[i] = mem_valid & (mem_rid==i), combinational.
  - If mem_rid >= N, no valid bit is set.
  - The return path is independent of the command state. Reads return concurrently with later grants.
- Reset asserted mid-burst: all state returns to reset values on the next edge, and mem_req drops in that cycle. The partially written burst is abandoned; the SDRAM controller is reset in the same domain.
- Simultaneous events:
  - mem_ack and a req change in the same cycle: mem_ack wins, because req is sampled only in IDLE and for withdrawal.
  - mem_valid during WBURST is routed normally.

Test Plan:
- Reset, then req=4'b0001, wr=0, addr0=24'h000100, mem_ack on the 2nd mem_req cycle -> mem_req rises 1 cycle after req; mem_addr=000100, mem_id=0; ack[0] pulses once; back to IDLE.
- All four requesters issue reads continuously, mem_ack immediate -> grant order 0,1,2,3,0,1; each command separated by exactly one idle cycle.
- Requester 2 write with BURST=8 while requester 1 reads; mem_ack held high -> 8 consecutive ack[2] pulses with mem_wr=1 and mem_id=2; requester 1 is granted only after the 8th word.
- Mid-burst: requester 2 drops req after word 3 for 5 cycles -> mem_req=0 for those cycles; no grant goes to others; words 4..8 complete after req returns.
- mem_valid with mem_rid=3 for 8 cycles during an active write grant to 0 -> valid=4'b1000 for 8 cycles; ack/mem_req unaffected. mem_rid=3 with N=3 -> valid=0.
- Reset asserted at word 5 of a burst -> next cycle mem_req=0, ack=0, state IDLE; after release, requester 0 wins first if it is requesting.
